module_serial_alu_sequencer: RTL and testbench

- Bit-serial 32-bit MIPS ALU engine: accepts operands and a 3-bit ALU op over a valid/ready handshake.
- Feeds one bit per clock, LSB first, through a single 1-bit ALU slice, then presents the full result with zero, overflow and carry flags.
- Drives the 1-bit slice interface from the sequencing side.
- Sits beside the datapath as the area-minimal ALU for the multicycle processor variant.

---
 rtl/module_serial_alu_sequencer_pkg.sv | 21 ++
 rtl/module_serial_alu_sequencer_if.sv | 26 ++
 rtl/module_serial_alu_sequencer_slice.sv | 33 +++
 rtl/module_serial_alu_sequencer.sv | 168 ++++++++++++++++
 tb/tb_module_serial_alu_sequencer.sv | 166 ++++++++++++++++
 5 files changed

// File: rtl/module_serial_alu_sequencer_pkg.sv
// Shared ALU opcode constants and sequencer state encoding.
package module_serial_alu_sequencer_pkg;

  localparam logic [2:0] ALUOP_AND = 3'b000;
  localparam logic [2:0] ALUOP_OR  = 3'b001;
  localparam logic [2:0] ALUOP_ADD = 3'b010;
  localparam logic [2:0] ALUOP_SUB = 3'b110;
  localparam logic [2:0] ALUOP_SLT = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // SUB and SLT both run the adder with B inverted and carry-in forced to 1.
  function automatic logic is_subtract(input logic [2:0] op);
    return (op == ALUOP_SUB) || (op == ALUOP_SLT);
  endfunction

endpackage

// File: rtl/module_serial_alu_sequencer_if.sv
// Operand/op request and result/flag response channels of the serial ALU.
interface module_serial_alu_sequencer_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [2:0]       aluop;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             zero;
  logic             overflow;
  logic             carry_out;

  modport master (
    output in_valid, a, b, aluop, out_ready,
    input  in_ready, out_valid, result, zero, overflow, carry_out
  );

  modport slave (
    input  in_valid, a, b, aluop, out_ready,
    output in_ready, out_valid, result, zero, overflow, carry_out
  );
endinterface

// File: rtl/module_serial_alu_sequencer_slice.sv
// Classic MIPS 1-bit ALU slice: AND/OR/full-add with optional B inversion, SLT passes lessi.
module module_alu_bit_slice
  import module_serial_alu_sequencer_pkg::*;
(
  input  logic       ai,
  input  logic       bi,
  input  logic       binvert,
  input  logic       ci,
  input  logic       lessi,
  input  logic [2:0] aluop,
  output logic       ri,
  output logic       co
);

  logic bb;

  assign bb = bi ^ binvert;
  assign co = (ai & bb) | (ai & ci) | (bb & ci);

  // Result multiplexer; unknown opcodes yield 0.
  always_comb begin
    ri = 1'b0;
    case (aluop)
      ALUOP_AND: ri = ai & bb;
      ALUOP_OR:  ri = ai | bb;
      ALUOP_ADD,
      ALUOP_SUB: ri = ai ^ bb ^ ci;
      ALUOP_SLT: ri = lessi;
      default:   ri = 1'b0;
    endcase
  end

endmodule

// File: rtl/module_serial_alu_sequencer.sv
// Bit-serial ALU: streams operands LSB first through one 1-bit slice, then
// presents the full-width result with zero/overflow/carry flags.
module module_serial_alu_sequencer
  import module_serial_alu_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 5
) (
  input logic                          clk,
  input logic                          reset,
  module_serial_alu_sequencer_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  seq_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_q, zero_d;
  logic             ovf_q, ovf_d;
  logic             cout_q, cout_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic             binv_c;
  logic             ri_c;
  logic             co_c;
  logic             ovf_raw_c;
  logic             sum_msb_c;
  logic [WIDTH-1:0] word_c;

  assign binv_c    = is_subtract(op_q);
  assign ovf_raw_c = carry_q ^ co_c;
  // Adder sum of the current bit, independent of the slice's SLT routing.
  assign sum_msb_c = a_q[0] ^ b_q[0] ^ binv_c ^ carry_q;
  assign word_c    = {ri_c, sh_q[WIDTH-1:1]};

  module_alu_bit_slice u_slice (
    .ai      (a_q[0]),
    .bi      (b_q[0]),
    .binvert (binv_c),
    .ci      (carry_q),
    .lessi   (1'b0),
    .aluop   (op_q),
    .ri      (ri_c),
    .co      (co_c)
  );

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      sh_q        <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      ovf_q       <= 1'b0;
      cout_q      <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      sh_q        <= sh_d;
      cnt_q       <= cnt_d;
      carry_q     <= carry_d;
      result_q    <= result_d;
      zero_q      <= zero_d;
      ovf_q       <= ovf_d;
      cout_q      <= cout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state, bit sequencing and flag capture on the final RUN edge.
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    op_d        = op_q;
    sh_d        = sh_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    result_d    = result_q;
    zero_d      = zero_q;
    ovf_d       = ovf_q;
    cout_d      = cout_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d        = bus.a;
          b_d        = bus.b;
          op_d       = bus.aluop;
          sh_d       = '0;
          cnt_d      = '0;
          carry_d    = is_subtract(bus.aluop);
          in_ready_d = 1'b0;
          state_d    = RUN;
        end
      end

      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = word_c;
        carry_d = co_c;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_LAST) begin
          cnt_d       = '0;
          out_valid_d = 1'b1;
          state_d     = DONE;
          ovf_d       = 1'b0;
          cout_d      = 1'b0;
          case (op_q)
            ALUOP_AND,
            ALUOP_OR:  result_d = word_c;
            ALUOP_ADD,
            ALUOP_SUB: begin
              result_d = word_c;
              ovf_d    = ovf_raw_c;
              cout_d   = co_c;
            end
            ALUOP_SLT: result_d = WIDTH'(sum_msb_c ^ ovf_raw_c);
            default:   result_d = '0;
          endcase
          zero_d = (result_d == '0);
        end
      end

      DONE: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.zero      = zero_q;
  assign bus.overflow  = ovf_q;
  assign bus.carry_out = cout_q;

endmodule

// File: tb/tb_module_serial_alu_sequencer.sv
// Randomized self-checking bench for the bit-serial ALU against a word-level model.
module tb_module_serial_alu_sequencer;

  localparam int unsigned WIDTH = 32;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;

  module_serial_alu_sequencer_if #(.WIDTH(WIDTH)) bus ();

  module_serial_alu_sequencer #(.WIDTH(WIDTH), .CNT_W(5)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [WIDTH-1:0] got, input logic [WIDTH-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word-level reference: plain two's-complement arithmetic.
  function automatic void ref_alu(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                  input logic [WIDTH-1:0] b, output logic [WIDTH-1:0] res,
                                  output logic ovf, output logic cout);
    logic [WIDTH:0] s;
    res  = '0;
    ovf  = 1'b0;
    cout = 1'b0;
    case (op)
      3'b000: res = a & b;
      3'b001: res = a | b;
      3'b010: begin
        s    = {1'b0, a} + {1'b0, b};
        res  = s[WIDTH-1:0];
        cout = s[WIDTH];
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b110: begin
        s    = {1'b0, a} + {1'b0, ~b} + 33'd1;
        res  = s[WIDTH-1:0];
        cout = s[WIDTH];
        ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (res[WIDTH-1] != a[WIDTH-1]);
      end
      3'b111: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: res = '0;
    endcase
  endfunction

  // Issue one op, check latency and outputs, hold DONE for 'hold' cycles, then drain.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [WIDTH-1:0] a,
                        input logic [WIDTH-1:0] b, input int hold);
    logic [WIDTH-1:0] er;
    logic             eo, ec;
    int               lat;
    ref_alu(op, a, b, er, eo, ec);
    check({tag, ".in_ready"}, WIDTH'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.a        = a;
    bus.b        = b;
    bus.aluop    = op;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    bus.aluop    = 3'($urandom);
    lat = 0;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, ".latency"}, WIDTH'(lat), WIDTH);
    check({tag, ".result"}, bus.result, er);
    check({tag, ".flags"}, WIDTH'({bus.zero, bus.overflow, bus.carry_out}),
          WIDTH'({er == '0, eo, ec}));
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      bus.a        = $urandom;
      bus.b        = $urandom;
      @(posedge clk); #1;
      check({tag, ".hold"}, WIDTH'({bus.out_valid, bus.in_ready}), 32'd2);
      check({tag, ".hold_result"}, bus.result, er);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    check({tag, ".drain"}, WIDTH'({bus.out_valid, bus.in_ready}), 32'd1);
    check({tag, ".kept"}, bus.result, er);
  endtask

  localparam logic [2:0] OPS [8] = '{3'b000, 3'b001, 3'b010, 3'b110, 3'b111,
                                     3'b010, 3'b110, 3'b111};
  localparam logic [31:0] EDGE_VALS [6] = '{32'h0, 32'hFFFFFFFF, 32'h80000000,
                                            32'h7FFFFFFF, 32'h1, 32'h7};

  function automatic logic [WIDTH-1:0] pick_operand();
    if ($urandom_range(0, 3) == 0) return EDGE_VALS[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    logic [2:0] op;
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.aluop     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset.handshake", WIDTH'({bus.out_valid, bus.in_ready}), 32'd1);
    check("reset.result", bus.result, '0);
    check("reset.flags", WIDTH'({bus.zero, bus.overflow, bus.carry_out}), '0);
    reset = 1'b0;
    @(posedge clk); #1;

    run_op("add_ovf", 3'b010, 32'h7FFFFFFF, 32'h00000001, 0);
    run_op("sub_neg", 3'b110, 32'd5, 32'd7, 0);
    run_op("sub_zero", 3'b110, 32'd7, 32'd7, 0);
    run_op("slt_neg", 3'b111, 32'hFFFFFFFF, 32'd1, 0);
    run_op("slt_ovf", 3'b111, 32'h7FFFFFFF, 32'h80000000, 0);
    run_op("slt_min", 3'b111, 32'h80000000, 32'h7FFFFFFF, 0);
    run_op("and", 3'b000, 32'hF0F0F0F0, 32'hFF00FF00, 10);
    run_op("or", 3'b001, 32'hF0F0F0F0, 32'hFF00FF00, 0);
    run_op("bad_op", 3'b011, 32'h12345678, 32'h9ABCDEF0, 0);

    // Reset in the middle of an operation.
    bus.in_valid = 1'b1;
    bus.a        = 32'h00001234;
    bus.b        = 32'h00000001;
    bus.aluop    = 3'b010;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("midrun.handshake", WIDTH'({bus.out_valid, bus.in_ready}), 32'd1);
    check("midrun.result", bus.result, '0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    run_op("post_reset_add", 3'b010, 32'd3, 32'd4, 0);

    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 5)) : OPS[$urandom_range(0, 7)];
      run_op($sformatf("rand%0d", n), op, pick_operand(), pick_operand(),
             int'($urandom_range(0, 3)));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
